data_mem_responder: RTL and testbench

Responder end of the core's load/store interface: it accepts one data-memory request at a time from the load/store path, waits a programmable number of cycles, and returns a one-cycle response. A response carries aligned, sign- or zero-extended read data, or a store acknowledge, or a misalignment error. It sits beside the register file in the datapath and supplies the load values that writeback later writes into it.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/load_store_align.sv | 27 ++
 rtl/data_mem_responder.sv | 97 +++++++++
 tb/tb_data_mem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, responder FSM states and the alignment rule
package dmem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    // size 2'b11 falls through to the word rule
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? lo[0] : |lo;
    endfunction
endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores and lane extraction/extension for loads
// Ports: size_i/addr_lo_i/unsigned_i describe the access, raw_i is the stored word,
// wdata_i the right-justified store data; be_o byte enables, store_o lane-replicated
// store word, load_o shifted and extended load word.
module load_store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] store_o,
    output logic [31:0] load_o
);
    logic [31:0] shifted;
    always_comb begin
        shifted = raw_i >> {addr_lo_i, 3'b000};
        be_o = size_i == SIZE_BYTE ? 4'b0001 << addr_lo_i :
               size_i == SIZE_HALF ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        store_o = size_i == SIZE_BYTE ? {4{wdata_i[7:0]}} :
                  size_i == SIZE_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        load_o = size_i == SIZE_BYTE ? {{24{~unsigned_i & shifted[7]}}, shifted[7:0]} :
                 size_i == SIZE_HALF ? {{16{~unsigned_i & shifted[15]}}, shifted[15:0]} : raw_i;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with programmable latency
// Ports: clock/reset (sync, active-high); Req/ReqWrite/Addr/WriteData/Size/Unsigned form
// the request; ReqReady accepts it; RespValid strobes one cycle with ReadData/Misaligned.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Req,
    input  logic        ReqWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        Misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic          uns_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          resp_valid_q;
    logic          mis_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   store_word;
    logic [31:0]   load_word;
    logic          bad;
    logic          commit;
    logic          unused_addr;
    assign unused_addr = ^Addr[31:AW+2];
    assign idx         = addr_q[AW+1:2];
    assign bad         = misaligned(size_q, addr_q[1:0]);
    // reset on the WAIT->RESP edge wins, so an abandoned store never lands
    assign commit      = !reset && state_q == WAIT && cnt_q == '0;
    assign ReqReady    = state_q == IDLE;
    assign RespValid   = resp_valid_q;
    assign ReadData    = rdata_q;
    assign Misaligned  = mis_q;
    load_store_align u_align (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .unsigned_i(uns_q),
        .raw_i     (mem[idx]),
        .wdata_i   (wdata_q),
        .be_o      (be),
        .store_o   (store_word),
        .load_o    (load_word)
    );
    always_ff @(posedge clock) begin
        if (commit && write_q && !bad)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= store_word[8*b +: 8];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            mis_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (Req) begin
                    state_q <= WAIT;
                    cnt_q   <= 4'(LATENCY);
                    write_q <= ReqWrite;
                    addr_q  <= Addr[AW+1:0];
                    wdata_q <= WriteData;
                    size_q  <= Size;
                    uns_q   <= Unsigned;
                end
                WAIT: if (cnt_q == '0) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    mis_q        <= bad;
                    rdata_q      <= (bad || write_q) ? '0 : load_word;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over three responders with LATENCY 2, 0 and 15
module tb_data_mem_responder;
    import dmem_pkg::*;
    typedef struct packed {logic [31:0] data; logic mis;} exp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  mis;
    logic [31:0] rd [3];
    int          sel;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(g == 0 ? 2 : g == 1 ? 0 : 15)) u_dut (
            .clock     (clk),
            .reset     (rst),
            .Req       (req && sel == g),
            .ReqWrite  (rw),
            .Addr      (addr),
            .WriteData (wd),
            .Size      (size),
            .Unsigned  (uns),
            .ReqReady  (rdy[g]),
            .RespValid (rv[g]),
            .ReadData  (rd[g]),
            .Misaligned(mis[g])
        );
    end
    function automatic int lat(input int s);
        return s == 0 ? 2 : s == 1 ? 0 : 15;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (latency %0d): got %h expected %h", tag, lat(sel), got, exp);
        end
    endtask
    task automatic wait_ready();
        int n = 0;
        while (!rdy[sel] && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input logic [31:0] er, input logic em);
        int n;
        int t0;
        exp_t e;
        wait_ready();
        sb.push_back('{er, em});
        req = 1'b1; rw = w; addr = a; wd = d; size = sz; uns = u;
        @(negedge clk);
        req = 1'b0;
        t0 = cyc;
        n = 0;
        while (!rv[sel] && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, " valid"}, 32'(rv[sel]), 32'd1);
        check({tag, " latency"}, 32'(cyc - t0), 32'(lat(sel) + 1));
        check({tag, " data"}, rd[sel], e.data);
        check({tag, " mis"}, 32'(mis[sel]), 32'(e.mis));
        @(negedge clk);
        check({tag, " strobe"}, 32'(rv[sel]), 32'd0);
        check({tag, " hold"}, rd[sel], e.data);
    endtask
    task automatic burst(input logic [31:0] a, input logic [31:0] er);
        int acc[$];
        int got = 0;
        int n = 0;
        exp_t e;
        req = 1'b1; rw = 1'b0; addr = a; size = SIZE_WORD; uns = 1'b0;
        while ((acc.size() < 3 || got < 3) && n < 200) begin
            if (rv[sel] && sb.size() > 0) begin
                e = sb.pop_front();
                check("burst data", rd[sel], e.data);
                got++;
            end
            if (acc.size() == 3) req = 1'b0;
            else if (rdy[sel]) begin
                sb.push_back('{er, 1'b0});
                acc.push_back(cyc + 1);
            end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        check("burst responses", 32'(got), 32'd3);
        check("burst accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("burst gap1", 32'(acc[1] - acc[0]), 32'(lat(sel) + 3));
            check("burst gap2", 32'(acc[2] - acc[1]), 32'(lat(sel) + 3));
        end
    endtask
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
        int seen = 0;
        wait_ready();
        req = 1'b1; rw = 1'b1; addr = a; wd = d; size = SIZE_WORD; uns = 1'b0;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen |= 32'(rv[sel]);
        end
        rst = 1'b0;
        repeat (lat(sel) + 4) begin
            @(negedge clk);
            seen |= 32'(rv[sel]);
        end
        check("abort no resp", 32'(seen), 32'd0);
        check("abort ready", 32'(rdy[sel]), 32'd1);
        check("abort rdata", rd[sel], 32'd0);
    endtask
    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wd = '0; size = '0; uns = 1'b0; sel = 0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check("reset valid", 32'(rv[sel]), 32'd0);
            check("reset data", rd[sel], 32'd0);
            check("reset mis", 32'(mis[sel]), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("reset ready", 32'(rdy[sel]), 32'd1);
            xact("st word", 1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 0, 32'h0, 0);
            xact("ld word", 0, 32'h10, 32'h0, SIZE_WORD, 0, 32'hDEADBEEF, 0);
            xact("ld byte s", 0, 32'h13, 32'h0, SIZE_BYTE, 0, 32'hFFFFFFDE, 0);
            xact("ld byte u", 0, 32'h13, 32'h0, SIZE_BYTE, 1, 32'h000000DE, 0);
            xact("ld byte1 s", 0, 32'h11, 32'h0, SIZE_BYTE, 0, 32'hFFFFFFBE, 0);
            xact("ld half s", 0, 32'h10, 32'h0, SIZE_HALF, 0, 32'hFFFFBEEF, 0);
            xact("ld half u", 0, 32'h12, 32'h0, SIZE_HALF, 1, 32'h0000DEAD, 0);
            xact("st half", 1, 32'h12, 32'h1234, SIZE_HALF, 0, 32'h0, 0);
            xact("ld after half", 0, 32'h10, 32'h0, SIZE_WORD, 0, 32'h1234BEEF, 0);
            xact("st byte", 1, 32'h11, 32'h555555AA, SIZE_BYTE, 0, 32'h0, 0);
            xact("ld after byte", 0, 32'h10, 32'h0, SIZE_WORD, 0, 32'h1234AAEF, 0);
            xact("st word mis", 1, 32'h11, 32'hFFFFFFFF, SIZE_WORD, 0, 32'h0, 1);
            xact("st half mis", 1, 32'h13, 32'hFFFF, SIZE_HALF, 0, 32'h0, 1);
            xact("ld half mis", 0, 32'h11, 32'h0, SIZE_HALF, 0, 32'h0, 1);
            xact("ld size3 mis", 0, 32'h12, 32'h0, 2'b11, 1, 32'h0, 1);
            xact("ld after mis", 0, 32'h10, 32'h0, SIZE_WORD, 0, 32'h1234AAEF, 0);
            xact("ld size3", 0, 32'h10, 32'h0, 2'b11, 1, 32'h1234AAEF, 0);
            xact("st wrap", 1, 32'h400, 32'hCAFEF00D, SIZE_WORD, 0, 32'h0, 0);
            xact("ld wrap", 0, 32'h0, 32'h0, SIZE_WORD, 0, 32'hCAFEF00D, 0);
            xact("ld wrap hi", 0, 32'hFFFFF000, 32'h0, SIZE_WORD, 0, 32'hCAFEF00D, 0);
            burst(32'h10, 32'h1234AAEF);
            xact("st base", 1, 32'h20, 32'h11112222, SIZE_WORD, 0, 32'h0, 0);
            abort_store(32'h20, 32'h99999999);
            xact("ld after abort", 0, 32'h20, 32'h0, SIZE_WORD, 0, 32'h11112222, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
